adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 62 ++++++
 tb/tb_adder_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one external combinational adder
// among NREQ requesters, with a single registered result slot.
module adder_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_i1,
  output logic [WIDTH-1:0]      add_i2,
  input  logic [WIDTH-1:0]      add_sum,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IW-1:0]         resp_id,
  output logic [WIDTH-1:0]      resp_sum
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_id;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    w_win;
  logic             w_any;
  logic             w_grant;
  // Scan from the farthest offset down so the nearest valid requester to r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[(int'(r_ptr) + i) % NREQ]) begin
        w_win = IW'((int'(r_ptr) + i) % NREQ);
        w_any = 1'b1;
      end
  end
  assign w_grant    = !reset && w_any && (r_state == EMPTY || resp_ready);
  assign req_ready  = w_grant ? NREQ'(1) << w_win : '0;
  assign add_i1     = w_grant ? req_a[int'(w_win)*WIDTH +: WIDTH] : '0;
  assign add_i2     = w_grant ? req_b[int'(w_win)*WIDTH +: WIDTH] : '0;
  assign resp_valid = (r_state == FULL);
  assign resp_id    = r_id;
  assign resp_sum   = r_sum;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_id    <= '0;
      r_sum   <= '0;
    end else if (w_grant) begin
      r_state <= FULL;
      r_sum   <= add_sum;
      r_id    <= w_win;
      r_ptr   <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end else if (resp_ready) begin
      r_state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random checks of adder_arbiter against a
// round-robin transaction model; the bench also plays the external adder.
module tb_adder_arbiter;
  localparam int NREQ  = 3;
  localparam int WIDTH = 32;
  localparam int IW    = 2;
  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0]      add_i1;
  logic [WIDTH-1:0]      add_i2;
  logic [WIDTH-1:0]      add_sum;
  logic                  resp_valid;
  logic                  resp_ready = 1'b0;
  logic [IW-1:0]         resp_id;
  logic [WIDTH-1:0]      resp_sum;
  int n_chk = 0;
  int n_pass = 0;
  bit m_full;
  int m_ptr;
  int m_id;
  logic [WIDTH-1:0] m_sum;
  always #5 clk = ~clk;
  assign add_sum = add_i1 + add_i2;
  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_i1(add_i1), .add_i2(add_i2),
    .add_sum(add_sum), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic set_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask
  task automatic do_reset(input logic [NREQ-1:0] v);
    @(negedge clk);
    req_valid = v;
    resp_ready = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_sum", resp_sum, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_i1", add_i1, 0);
    chk("rst_i2", add_i2, 0);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;
    m_full = 0;
    m_ptr = 0;
    m_id = 0;
    m_sum = '0;
  endtask
  task automatic cycle(input logic [NREQ-1:0] v, input logic rr);
    int win;
    logic [WIDTH-1:0] ea, eb;
    @(negedge clk);
    req_valid = v;
    resp_ready = rr;
    #1;
    win = -1;
    ea = '0;
    eb = '0;
    if (!m_full || rr)
      for (int i = 0; i < NREQ; i++)
        if (win < 0 && v[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
    if (win >= 0) begin
      ea = req_a[win*WIDTH +: WIDTH];
      eb = req_b[win*WIDTH +: WIDTH];
    end
    chk("ready", req_ready, (win >= 0) ? (64'd1 << win) : 64'd0);
    chk("i1", add_i1, ea);
    chk("i2", add_i2, eb);
    @(posedge clk);
    if (win >= 0) begin
      m_full = 1;
      m_id = win;
      m_sum = ea + eb;
      m_ptr = (win + 1) % NREQ;
    end else if (rr) m_full = 0;
    #1;
    chk("valid", resp_valid, m_full);
    chk("id", resp_id, m_id);
    chk("sum", resp_sum, m_sum);
  endtask
  initial begin
    do_reset('1);
    set_op(0, 32'd5, 32'd7);
    cycle(3'b001, 1'b1);
    chk("single_sum", resp_sum, 12);
    do_reset('0);
    for (int k = 0; k < NREQ; k++) set_op(k, 32'(100 * k), 32'(k + 1));
    repeat (4) cycle(3'b111, 1'b1);
    chk("contend_last_id", resp_id, 0);
    set_op(1, 32'hAAAA, 32'h5555);
    repeat (3) cycle(3'b010, 1'b0);
    cycle(3'b010, 1'b1);
    chk("bp_id", resp_id, 1);
    chk("bp_sum", resp_sum, 32'hFFFF);
    set_op(2, 32'hFFFF_FFFF, 32'd2);
    cycle(3'b100, 1'b1);
    chk("wrap_sum", resp_sum, 1);
    set_op(0, 32'h1000, 32'h0234);
    cycle(3'b001, 1'b1);
    chk("pre_rst_sum", resp_sum, 32'h1234);
    do_reset(3'b110);
    cycle(3'b110, 1'b1);
    chk("post_rst_id", resp_id, 1);
    repeat (10) cycle(3'b000, 1'b1);
    cycle(3'b111, 1'b1);
    chk("idle_ptr_id", resp_id, 2);
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NREQ; k++)
        set_op(k, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom);
      cycle(NREQ'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
